dwrr_input_queues: RTL and testbench

//  Per-requestor packet queues sitting directly upstream of the DWRR arbiter.
//  - Buffers packets from NUM_REQS ingress ports.
//  - Drives the arbiter's reqs vector (queue non-empty).
//  - Consumes the arbiter's one-hot gnt: pops the granted queue into a single registered egress stage.
//  - Each pop is exactly one PSIZE packet, matching the arbiter's deficit deduction.

---
 rtl/dwrr_pkg.sv | 23 ++
 rtl/dwrr_input_queues_if.sv | 28 ++
 rtl/dwrr_queue_fifo.sv | 54 +++++
 rtl/dwrr_input_queues.sv | 83 ++++++++
 tb/tb_dwrr_input_queues.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dwrr_pkg.sv
// Shared constants and types for the DWRR ingress queues.
// Per-queue bookkeeping lives in one packed struct so it can be probed as a unit.
package dwrr_pkg;

    localparam int NUM_REQS = 4;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 4;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int PORT_W   = $clog2(NUM_REQS);

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [PTR_W-1:0] wptr;
        logic [PTR_W-1:0] rptr;
    } q_state_t;

    // True when more than one bit of v is set.
    function automatic logic multi_hot(input logic [NUM_REQS-1:0] v);
        return (v & (v - NUM_REQS'(1))) != '0;
    endfunction

endpackage

// File: rtl/dwrr_input_queues_if.sv
// Ingress, arbiter and egress signals of the DWRR input queues.
// Ingress beat transfers on in_valid[i] & in_ready[i]; egress beat on out_valid & out_ready;
// valid must not depend on ready, and a source holding valid keeps its data stable until accepted.
interface dwrr_input_queues_if;
    import dwrr_pkg::*;

    logic [NUM_REQS-1:0]        in_valid;
    logic [NUM_REQS*DATA_W-1:0] in_data;
    logic [NUM_REQS-1:0]        in_ready;
    logic [NUM_REQS-1:0]        reqs;
    logic [NUM_REQS-1:0]        gnt;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [PORT_W-1:0]          out_port;
    logic                       out_ready;
    logic                       err;

    modport slave (
        input  in_valid, in_data, gnt, out_ready,
        output in_ready, reqs, out_valid, out_data, out_port, err
    );

    modport master (
        output in_valid, in_data, gnt, out_ready,
        input  in_ready, reqs, out_valid, out_data, out_port, err
    );

endinterface

// File: rtl/dwrr_queue_fifo.sv
// One requestor's packet FIFO: synchronous push/pop, occupancy count and a
// combinational head read so the top can load the egress register in the pop cycle.
module dwrr_queue_fifo
    import dwrr_pkg::*;
#(
    parameter int DWID = DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [DWID-1:0] i_wdata,
    output logic [DWID-1:0] o_rdata,
    output logic            o_full,
    output logic            o_empty
);

    q_state_t        r_state;
    logic [DWID-1:0] r_mem [DEPTH];
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_state.count == CNT_W'(DEPTH));
    assign o_empty = (r_state.count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_rdata = r_mem[r_state.rptr];

    // Storage is not reset: a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_state.wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= '0;
        end else begin
            if (w_push) begin
                r_state.wptr <= r_state.wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_state.rptr <= r_state.rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_state.count <= r_state.count + CNT_W'(1);
                2'b01:   r_state.count <= r_state.count - CNT_W'(1);
                default: r_state.count <= r_state.count;
            endcase
        end
    end

endmodule

// File: rtl/dwrr_input_queues.sv
// Per-requestor queues in front of the DWRR arbiter: drives reqs, pops the
// granted queue into a single registered egress stage, flags illegal grants.
module dwrr_input_queues
    import dwrr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dwrr_input_queues_if.slave   bus
);

    logic [NUM_REQS-1:0] w_full;
    logic [NUM_REQS-1:0] w_empty;
    logic [NUM_REQS-1:0] w_push;
    logic [NUM_REQS-1:0] w_pop;
    logic [DATA_W-1:0]   w_head [NUM_REQS];
    logic                w_stall;
    logic                w_illegal;
    logic [DATA_W-1:0]   w_sel_data;
    logic [PORT_W-1:0]   w_sel_port;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [PORT_W-1:0]   r_out_port;
    logic                r_err;

    assign w_stall   = r_out_valid & ~bus.out_ready;
    assign w_illegal = multi_hot(bus.gnt) | (|(bus.gnt & w_empty)) | ((|bus.gnt) & w_stall);
    // A legal grant is one-hot, targets a non-empty queue and arrives unstalled.
    assign w_pop     = w_illegal ? '0 : bus.gnt;
    assign w_push    = bus.in_valid & ~w_full;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_q
        dwrr_queue_fifo #(.DWID(DATA_W)) u_q (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_wdata (bus.in_data[g*DATA_W +: DATA_W]),
            .o_rdata (w_head[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_port = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_pop[i]) begin
                w_sel_data = w_head[i];
                w_sel_port = PORT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_port  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (|w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_port  <= w_sel_port;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.reqs      = ~w_empty & {NUM_REQS{~w_stall}};
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_port  = r_out_port;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_dwrr_input_queues.sv
// Directed bench for dwrr_input_queues: a vector table for fill/pop/stall,
// then hand-written sequences for wrap-around, illegal grants and async reset.
module tb_dwrr_input_queues;
    import dwrr_pkg::*;

    typedef struct {
        logic [3:0]  iv;
        logic [31:0] idata;
        logic [3:0]  gnt;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic [3:0]  e_reqs;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_op;
        logic        e_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [17];
    logic [7:0] exp_q [$];

    dwrr_input_queues_if bus ();

    dwrr_input_queues dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic [3:0] iv, logic [31:0] d, logic [3:0] g, logic r,
                                logic [3:0] erdy, logic [3:0] ereq, logic eov,
                                logic [7:0] eod, logic [1:0] eop, logic eerr);
        vec_t v;
        v.iv = iv; v.idata = d; v.gnt = g; v.ordy = r;
        v.e_rdy = erdy; v.e_reqs = ereq; v.e_ov = eov; v.e_od = eod; v.e_op = eop; v.e_err = eerr;
        return v;
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] iv, logic [31:0] d, logic [3:0] g, logic r);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.gnt       = g;
        bus.out_ready = r;
    endtask

    // Scoreboard compare
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic [3:0] erdy, logic [3:0] ereq, logic eov,
                             logic [7:0] eod, logic [1:0] eop, logic eerr);
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(erdy));
        check({tag, ".reqs"},      32'(bus.reqs),      32'(ereq));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(eov));
        check({tag, ".out_data"},  32'(bus.out_data),  32'(eod));
        check({tag, ".out_port"},  32'(bus.out_port),  32'(eop));
        check({tag, ".err"},       32'(bus.err),       32'(eerr));
    endtask

    initial begin
        logic [7:0] pkt;
        logic [7:0] exp_d;

        // Fill q0, push while full, ordered pop, then q2 stall/release
        vecs[0]  = mk(4'b0001, 32'h11, 4'b0000, 1'b1, 4'b1111, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[1]  = mk(4'b0001, 32'h22, 4'b0000, 1'b1, 4'b1111, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[2]  = mk(4'b0001, 32'h33, 4'b0000, 1'b1, 4'b1111, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[3]  = mk(4'b0001, 32'h44, 4'b0000, 1'b1, 4'b1110, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[4]  = mk(4'b0001, 32'h55, 4'b0000, 1'b1, 4'b1110, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0);
        vecs[5]  = mk(4'b0000, 32'h00, 4'b0001, 1'b1, 4'b1111, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b0);
        vecs[6]  = mk(4'b0000, 32'h00, 4'b0001, 1'b1, 4'b1111, 4'b0001, 1'b1, 8'h22, 2'd0, 1'b0);
        vecs[7]  = mk(4'b0000, 32'h00, 4'b0001, 1'b1, 4'b1111, 4'b0001, 1'b1, 8'h33, 2'd0, 1'b0);
        vecs[8]  = mk(4'b0000, 32'h00, 4'b0001, 1'b1, 4'b1111, 4'b0000, 1'b1, 8'h44, 2'd0, 1'b0);
        vecs[9]  = mk(4'b0000, 32'h00, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 8'h44, 2'd0, 1'b0);
        vecs[10] = mk(4'b0100, 32'h00A1_0000, 4'b0000, 1'b1, 4'b1111, 4'b0100, 1'b0, 8'h44, 2'd0, 1'b0);
        vecs[11] = mk(4'b0100, 32'h00A2_0000, 4'b0000, 1'b1, 4'b1111, 4'b0100, 1'b0, 8'h44, 2'd0, 1'b0);
        vecs[12] = mk(4'b0000, 32'h00, 4'b0100, 1'b0, 4'b1111, 4'b0000, 1'b1, 8'hA1, 2'd2, 1'b0);
        vecs[13] = mk(4'b0000, 32'h00, 4'b0000, 1'b0, 4'b1111, 4'b0000, 1'b1, 8'hA1, 2'd2, 1'b0);
        vecs[14] = mk(4'b0000, 32'h00, 4'b0000, 1'b1, 4'b1111, 4'b0100, 1'b0, 8'hA1, 2'd2, 1'b0);
        vecs[15] = mk(4'b0000, 32'h00, 4'b0100, 1'b1, 4'b1111, 4'b0000, 1'b1, 8'hA2, 2'd2, 1'b0);
        vecs[16] = mk(4'b0000, 32'h00, 4'b0000, 1'b1, 4'b1111, 4'b0000, 1'b0, 8'hA2, 2'd2, 1'b0);

        // Reset held with all ports pushing
        rst = 1'b0;
        drive(4'b1111, 32'hDEAD_BEEF, 4'b0000, 1'b1);
        tick();
        tick();
        check_all("reset", 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        rst = 1'b1;

        // No bypass: before the first push lands reqs is still clear
        drive(vecs[0].iv, vecs[0].idata, vecs[0].gnt, vecs[0].ordy);
        #1;
        check("nobypass.reqs", 32'(bus.reqs), 32'h0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].iv, vecs[i].idata, vecs[i].gnt, vecs[i].ordy);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_reqs, vecs[i].e_ov,
                      vecs[i].e_od, vecs[i].e_op, vecs[i].e_err);
        end

        // q1: three queued, then ten cycles of push+pop, pointers wrap several times
        pkt = 8'hB0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, {16'h0, pkt, 8'h0}, 4'b0000, 1'b1);
            exp_q.push_back(pkt);
            pkt++;
            tick();
        end
        check("q1fill.reqs", 32'(bus.reqs), 32'b0010);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0010, {16'h0, pkt, 8'h0}, 4'b0010, 1'b1);
            exp_d = exp_q.pop_front();
            exp_q.push_back(pkt);
            pkt++;
            tick();
            check($sformatf("pp%0d.out_data", i), 32'(bus.out_data), 32'(exp_d));
            check($sformatf("pp%0d.out_valid", i), 32'(bus.out_valid), 32'h1);
            check($sformatf("pp%0d.out_port", i), 32'(bus.out_port), 32'h1);
            check($sformatf("pp%0d.in_ready", i), 32'(bus.in_ready), 32'b1111);
        end
        drive(4'b0010, {16'h0, pkt, 8'h0}, 4'b0000, 1'b1);
        exp_q.push_back(pkt);
        tick();
        check("q1full.in_ready", 32'(bus.in_ready), 32'b1101);
        for (int i = 0; i < 4; i++) begin
            drive(4'b0000, 32'h0, 4'b0010, 1'b1);
            exp_d = exp_q.pop_front();
            tick();
            check($sformatf("drain%0d.out_data", i), 32'(bus.out_data), 32'(exp_d));
        end
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        tick();
        check("q1drain.reqs", 32'(bus.reqs), 32'h0);
        check("q1drain.out_valid", 32'(bus.out_valid), 32'h0);

        // Illegal grants: multi-hot, empty target, grant into a stall
        drive(4'b0011, 32'h0000_C1C0, 4'b0000, 1'b1);
        tick();
        check_all("ill_setup", 4'b1111, 4'b0011, 1'b0, 8'hBD, 2'd1, 1'b0);
        drive(4'b0000, 32'h0, 4'b0011, 1'b1);
        tick();
        check_all("ill_multi", 4'b1111, 4'b0011, 1'b0, 8'hBD, 2'd1, 1'b1);
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        tick();
        check("ill_sticky.err", 32'(bus.err), 32'h1);
        drive(4'b0000, 32'h0, 4'b1000, 1'b1);
        tick();
        check_all("ill_empty", 4'b1111, 4'b0011, 1'b0, 8'hBD, 2'd1, 1'b1);
        drive(4'b0000, 32'h0, 4'b0001, 1'b1);
        tick();
        check_all("legal_after", 4'b1111, 4'b0010, 1'b1, 8'hC0, 2'd0, 1'b1);
        drive(4'b0000, 32'h0, 4'b0010, 1'b0);
        tick();
        check_all("ill_stall", 4'b1111, 4'b0000, 1'b1, 8'hC0, 2'd0, 1'b1);
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        tick();
        check_all("stall_free", 4'b1111, 4'b0010, 1'b0, 8'hC0, 2'd0, 1'b1);

        // Asynchronous reset mid-stream, checked before any clock edge
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst.reqs", 32'(bus.reqs), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
